mode_ctrl: RTL and testbench

Front-panel controller for the world-clock top level. It owns the four shared push-button pulses and the display select, and routes each button press to exactly one of three functions: world clock, stopwatch or countdown timer. When the timer alarm fires, it pre-empts the display and button map so the user can silence the alarm, then restores the previous mode. It also returns an idle stopwatch or timer view to the clock after a timeout.

---
 rtl/mode_ctrl_pkg.sv | 68 ++++++
 rtl/mode_ctrl_btn_router.sv | 51 +++++
 rtl/mode_ctrl.sv | 120 ++++++++++++
 tb/tb_mode_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mode_ctrl_pkg.sv
// Shared encodings for the front-panel mode controller and the display mux.
package mode_ctrl_pkg;

    // Mode / FSM state encodings
    localparam logic [1:0] MODE_CLOCK = 2'd0;
    localparam logic [1:0] MODE_SW    = 2'd1;
    localparam logic [1:0] MODE_TIMER = 2'd2;
    localparam logic [1:0] MODE_ALARM = 2'd3;

    // Display mux select codes
    localparam logic [1:0] DISP_CLOCK = 2'd0;
    localparam logic [1:0] DISP_SW    = 2'd1;
    localparam logic [1:0] DISP_TIMER = 2'd2;

    // One-hot mode indicator {timer, sw, clock}
    localparam logic [2:0] LED_CLOCK = 3'b001;
    localparam logic [2:0] LED_SW    = 3'b010;
    localparam logic [2:0] LED_TIMER = 3'b100;

    // Shared push-button pulses
    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
    } keys_t;

    // Forwarded pulses to the three functions
    typedef struct packed {
        logic clk_adj_hr;
        logic clk_adj_min;
        logic clk_zone;
        logic sw_start_stop;
        logic sw_lap;
        logic sw_reset;
        logic tm_min;
        logic tm_sec;
        logic tm_start_stop;
        logic tm_reset;
    } pulses_t;

    // CLOCK -> SW -> TIMER -> CLOCK
    function automatic logic [1:0] next_mode(input logic [1:0] m);
        case (m)
            MODE_CLOCK: next_mode = MODE_SW;
            MODE_SW:    next_mode = MODE_TIMER;
            default:    next_mode = MODE_CLOCK;
        endcase
    endfunction

    // The alarm view shows the timer
    function automatic logic [1:0] disp_of(input logic [1:0] m);
        case (m)
            MODE_CLOCK: disp_of = DISP_CLOCK;
            MODE_SW:    disp_of = DISP_SW;
            default:    disp_of = DISP_TIMER;
        endcase
    endfunction

    function automatic logic [2:0] led_of(input logic [1:0] m);
        case (m)
            MODE_CLOCK: led_of = LED_CLOCK;
            MODE_SW:    led_of = LED_SW;
            default:    led_of = LED_TIMER;
        endcase
    endfunction

endpackage

// File: rtl/mode_ctrl_btn_router.sv
// Registered demux of the four shared keys onto the active function's pulses.
module btn_router
    import mode_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       drop,
    input  keys_t      keys,
    output pulses_t    pulses
);

    pulses_t pulses_nxt;

    // Route each key by the current mode; a mode change or alarm entry drops the cycle
    always_comb begin
        pulses_nxt = '0;
        if (!drop) begin
            case (mode)
                MODE_CLOCK: begin
                    pulses_nxt.clk_adj_hr  = keys.a;
                    pulses_nxt.clk_adj_min = keys.b;
                    pulses_nxt.clk_zone    = keys.c;
                end
                MODE_SW: begin
                    pulses_nxt.sw_lap        = keys.a;
                    pulses_nxt.sw_start_stop = keys.c;
                    pulses_nxt.sw_reset      = keys.d;
                end
                MODE_TIMER: begin
                    pulses_nxt.tm_min        = keys.a;
                    pulses_nxt.tm_sec        = keys.b;
                    pulses_nxt.tm_start_stop = keys.c;
                    pulses_nxt.tm_reset      = keys.d;
                end
                default: begin
                    // Alarm view: any of A/B/C silences with one start/stop pulse
                    pulses_nxt.tm_start_stop = keys.a | keys.b | keys.c;
                    pulses_nxt.tm_reset      = keys.d;
                end
            endcase
        end
    end

    // One-cycle-delayed, one-cycle-wide pulse register
    always_ff @(posedge clk) begin
        if (rst) pulses <= '0;
        else     pulses <= pulses_nxt;
    end

endmodule

// File: rtl/mode_ctrl.sv
// Front-panel mode FSM: mode cycling, alarm pre-emption and idle return to clock.
module mode_ctrl
    import mode_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES = 30000,
    parameter int CNT_W       = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode_p,
    input  logic       btn_a_p,
    input  logic       btn_b_p,
    input  logic       btn_c_p,
    input  logic       btn_d_p,
    input  logic       tm_alarm,
    input  logic       tm_run,
    input  logic       sw_run,
    output logic       clk_adj_hr_p,
    output logic       clk_adj_min_p,
    output logic       clk_zone_p,
    output logic       sw_start_stop_p,
    output logic       sw_lap_p,
    output logic       sw_reset_p,
    output logic       tm_btn_min_p,
    output logic       tm_btn_sec_p,
    output logic       tm_btn_start_stop_p,
    output logic       tm_btn_reset_p,
    output logic [1:0] disp_sel,
    output logic [2:0] mode_led,
    output logic       alarm_view
);

    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state, state_nxt;
    logic [1:0]       ret_mode, ret_nxt;
    logic [CNT_W-1:0] idle_cnt, idle_nxt;
    logic             alarm_d;
    logic             in_alarm, alarm_rise, press, fn_stopped, drop;
    keys_t            keys;
    pulses_t          pulses;

    assign keys       = {btn_a_p, btn_b_p, btn_c_p, btn_d_p};
    assign in_alarm   = (state == MODE_ALARM);
    assign alarm_rise = tm_alarm & ~alarm_d;
    assign press      = btn_mode_p | btn_a_p | btn_b_p | btn_c_p | btn_d_p;
    assign fn_stopped = ((state == MODE_SW) & ~sw_run) | ((state == MODE_TIMER) & ~tm_run);
    // Keys are dropped on the cycle the mode changes by button or alarm entry
    assign drop       = ~in_alarm & (alarm_rise | btn_mode_p);

    // Next state, return mode and idle counter; alarm edge beats mode button beats idle
    always_comb begin
        state_nxt = state;
        ret_nxt   = ret_mode;
        if (in_alarm) begin
            if (!tm_alarm) state_nxt = ret_mode;
        end else if (alarm_rise) begin
            ret_nxt   = state;
            state_nxt = MODE_ALARM;
        end else if (btn_mode_p) begin
            state_nxt = next_mode(state);
        end else if (!press && idle_cnt == IDLE_MAX && fn_stopped) begin
            state_nxt = MODE_CLOCK;
        end

        if (press || state == MODE_CLOCK || in_alarm) idle_nxt = '0;
        else if (idle_cnt == IDLE_MAX)                idle_nxt = fn_stopped ? '0 : idle_cnt;
        else                                          idle_nxt = idle_cnt + CNT_ONE;
    end

    // State registers; an alarm already high at reset counts as seen so it cannot re-trigger
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MODE_CLOCK;
            ret_mode <= MODE_CLOCK;
            idle_cnt <= '0;
            alarm_d  <= tm_alarm;
        end else begin
            state    <= state_nxt;
            ret_mode <= ret_nxt;
            idle_cnt <= idle_nxt;
            alarm_d  <= tm_alarm;
        end
    end

    // Registered display outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_sel   <= DISP_CLOCK;
            mode_led   <= LED_CLOCK;
            alarm_view <= 1'b0;
        end else begin
            disp_sel   <= disp_of(state_nxt);
            mode_led   <= led_of(state_nxt);
            alarm_view <= (state_nxt == MODE_ALARM);
        end
    end

    btn_router u_router (
        .clk    (clk),
        .rst    (rst),
        .mode   (state),
        .drop   (drop),
        .keys   (keys),
        .pulses (pulses)
    );

    assign clk_adj_hr_p        = pulses.clk_adj_hr;
    assign clk_adj_min_p       = pulses.clk_adj_min;
    assign clk_zone_p          = pulses.clk_zone;
    assign sw_start_stop_p     = pulses.sw_start_stop;
    assign sw_lap_p            = pulses.sw_lap;
    assign sw_reset_p          = pulses.sw_reset;
    assign tm_btn_min_p        = pulses.tm_min;
    assign tm_btn_sec_p        = pulses.tm_sec;
    assign tm_btn_start_stop_p = pulses.tm_start_stop;
    assign tm_btn_reset_p      = pulses.tm_reset;

endmodule

// File: tb/tb_mode_ctrl.sv
// Directed bench for mode_ctrl with a short idle timeout.
module tb_mode_ctrl;

    logic clk = 1'b0;
    logic rst, btn_mode_p, btn_a_p, btn_b_p, btn_c_p, btn_d_p, tm_alarm, tm_run, sw_run;
    logic clk_adj_hr_p, clk_adj_min_p, clk_zone_p, sw_start_stop_p, sw_lap_p, sw_reset_p;
    logic tm_btn_min_p, tm_btn_sec_p, tm_btn_start_stop_p, tm_btn_reset_p;
    logic [1:0] disp_sel;
    logic [2:0] mode_led;
    logic       alarm_view;
    logic [9:0] pv;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mode_ctrl #(.IDLE_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .btn_mode_p(btn_mode_p),
        .btn_a_p(btn_a_p), .btn_b_p(btn_b_p), .btn_c_p(btn_c_p), .btn_d_p(btn_d_p),
        .tm_alarm(tm_alarm), .tm_run(tm_run), .sw_run(sw_run),
        .clk_adj_hr_p(clk_adj_hr_p), .clk_adj_min_p(clk_adj_min_p), .clk_zone_p(clk_zone_p),
        .sw_start_stop_p(sw_start_stop_p), .sw_lap_p(sw_lap_p), .sw_reset_p(sw_reset_p),
        .tm_btn_min_p(tm_btn_min_p), .tm_btn_sec_p(tm_btn_sec_p),
        .tm_btn_start_stop_p(tm_btn_start_stop_p), .tm_btn_reset_p(tm_btn_reset_p),
        .disp_sel(disp_sel), .mode_led(mode_led), .alarm_view(alarm_view)
    );

    // [9]hr [8]min [7]zone [6]sw_ss [5]lap [4]sw_rst [3]tm_min [2]tm_sec [1]tm_ss [0]tm_rst
    assign pv = {clk_adj_hr_p, clk_adj_min_p, clk_zone_p, sw_start_stop_p, sw_lap_p,
                 sw_reset_p, tm_btn_min_p, tm_btn_sec_p, tm_btn_start_stop_p, tm_btn_reset_p};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_keys(input logic [3:0] v);
        {btn_a_p, btn_b_p, btn_c_p, btn_d_p} = v;
    endtask

    task automatic press_mode();
        btn_mode_p = 1'b1;
        step();
        btn_mode_p = 1'b0;
    endtask

    // Expected pulse vector per {mode, key}; keys a..d index 0..3
    logic [9:0] exp_map [3][4];

    initial begin
        exp_map[0][0] = 10'b1000000000; exp_map[0][1] = 10'b0100000000;
        exp_map[0][2] = 10'b0010000000; exp_map[0][3] = 10'b0000000000;
        exp_map[1][0] = 10'b0000100000; exp_map[1][1] = 10'b0000000000;
        exp_map[1][2] = 10'b0001000000; exp_map[1][3] = 10'b0000010000;
        exp_map[2][0] = 10'b0000001000; exp_map[2][1] = 10'b0000000100;
        exp_map[2][2] = 10'b0000000010; exp_map[2][3] = 10'b0000000001;

        rst = 1'b1; btn_mode_p = 1'b0; set_keys(4'b0000);
        tm_alarm = 1'b0; tm_run = 1'b0; sw_run = 1'b0;
        step(); step();
        chk("rst_disp", disp_sel, 2'd0);
        chk("rst_led", mode_led, 3'b001);
        chk("rst_av", alarm_view, 1'b0);
        chk("rst_pulses", pv, 10'd0);
        rst = 1'b0;
        step();

        // Mode cycling
        press_mode();
        chk("cyc1_disp", disp_sel, 2'd1); chk("cyc1_led", mode_led, 3'b010);
        chk("cyc1_pulses", pv, 10'd0);
        repeat (4) step();
        press_mode();
        chk("cyc2_disp", disp_sel, 2'd2); chk("cyc2_led", mode_led, 3'b100);
        repeat (4) step();
        press_mode();
        chk("cyc3_disp", disp_sel, 2'd0); chk("cyc3_led", mode_led, 3'b001);

        // Key map in each mode: pulse at +1, gone at +2
        for (int m = 0; m < 3; m++) begin
            for (int k = 0; k < 4; k++) begin
                logic [3:0] kv;
                kv = 4'b1000 >> k;
                set_keys(kv);
                step();
                set_keys(4'b0000);
                chk($sformatf("map_m%0d_k%0d", m, k), pv, exp_map[m][k]);
                step();
                chk($sformatf("map_m%0d_k%0d_w", m, k), pv, 10'd0);
            end
            press_mode();
        end
        chk("map_back_clock", disp_sel, 2'd0);

        // Mode + A together in CLOCK: mode wins, A dropped
        btn_mode_p = 1'b1; btn_a_p = 1'b1;
        step();
        btn_mode_p = 1'b0; btn_a_p = 1'b0;
        chk("modeA_disp", disp_sel, 2'd1);
        chk("modeA_pulses", pv, 10'd0);

        // Alarm pre-emption from SW
        tm_alarm = 1'b1;
        step();
        chk("al_av", alarm_view, 1'b1); chk("al_disp", disp_sel, 2'd2);
        chk("al_led", mode_led, 3'b100);
        press_mode();
        chk("al_mode_ign", disp_sel, 2'd2); chk("al_mode_av", alarm_view, 1'b1);
        chk("al_mode_pulses", pv, 10'd0);
        set_keys(4'b0100); step(); set_keys(4'b0000);
        chk("al_B", pv, 10'b0000000010);
        step();
        chk("al_B_w", pv, 10'd0);
        set_keys(4'b1110); step(); set_keys(4'b0000);
        chk("al_ABC", pv, 10'b0000000010);
        set_keys(4'b0001); step(); set_keys(4'b0000);
        chk("al_D", pv, 10'b0000000001);
        tm_alarm = 1'b0;
        step();
        chk("al_ret_disp", disp_sel, 2'd1); chk("al_ret_av", alarm_view, 1'b0);
        chk("al_ret_led", mode_led, 3'b010);

        // Alarm edge + mode (+ A) in SW: alarm wins, returns to SW
        tm_alarm = 1'b1; btn_mode_p = 1'b1; btn_a_p = 1'b1;
        step();
        btn_mode_p = 1'b0; btn_a_p = 1'b0;
        chk("alm_av", alarm_view, 1'b1); chk("alm_pulses", pv, 10'd0);
        tm_alarm = 1'b0;
        step();
        chk("alm_ret_disp", disp_sel, 2'd1);

        // Idle return from stopped TIMER after exactly 10 cycles
        press_mode();
        chk("idle_enter", disp_sel, 2'd2);
        for (int i = 1; i <= 9; i++) begin
            step();
            chk($sformatf("idle_hold%0d", i), disp_sel, 2'd2);
        end
        step();
        chk("idle_ret", disp_sel, 2'd0);

        // Running TIMER stays until tm_run drops
        tm_run = 1'b1;
        press_mode(); press_mode();
        chk("run_enter", disp_sel, 2'd2);
        repeat (15) step();
        chk("run_hold", disp_sel, 2'd2);
        tm_run = 1'b0;
        step();
        chk("run_ret", disp_sel, 2'd0);

        // Reset in alarm view with alarm held high
        press_mode();
        tm_alarm = 1'b1;
        step();
        chk("ra_av", alarm_view, 1'b1);
        rst = 1'b1; btn_a_p = 1'b1;
        step();
        rst = 1'b0; btn_a_p = 1'b0;
        chk("ra_disp", disp_sel, 2'd0); chk("ra_av0", alarm_view, 1'b0);
        chk("ra_led", mode_led, 3'b001); chk("ra_pulses", pv, 10'd0);
        repeat (3) step();
        chk("ra_noreentry", alarm_view, 1'b0);
        chk("ra_noreentry_disp", disp_sel, 2'd0);
        tm_alarm = 1'b0; step();
        tm_alarm = 1'b1; step();
        chk("ra_reentry", alarm_view, 1'b1); chk("ra_reentry_disp", disp_sel, 2'd2);
        tm_alarm = 1'b0; step();
        chk("ra_ret_clock", disp_sel, 2'd0); chk("ra_ret_av", alarm_view, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
